pcm_mem_mm: RTL and testbench

PCM_MEM_MM -- requirements
Module: pcm_mem_mm

---
 rtl/pcm_mem_mm.sv | 133 +++++++++++++
 tb/tb_pcm_mem_mm.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/pcm_mem_mm.sv
// Single-port word-addressed memory with byte enables, a 1- or 2-stage registered read path,
// and a background zero-fill sequencer that locks out accesses while it sweeps the array.
module pcm_mem_mm #(
    parameter int unsigned ADDR_W       = 11,
    parameter int unsigned DATA_W       = 16,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                init,
    input  logic [ADDR_W-1:0]   address,
    input  logic                chipselect,
    input  logic                clken,
    input  logic                write,
    input  logic [DATA_W-1:0]   writedata,
    input  logic [DATA_W/8-1:0] byteenable,
    output logic [DATA_W-1:0]   readdata,
    output logic                readdatavalid,
    output logic                busy
);

    localparam int unsigned NB    = DATA_W / 8;
    localparam int unsigned DEPTH = 2 ** ADDR_W;

    typedef enum logic [0:0] {StIdle, StClear} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              accept;
    logic              rd_acc;
    logic              wr_acc;
    logic [DATA_W-1:0] rd_word;
    logic [DATA_W-1:0] rd_q;
    logic              rv_q;

    assign busy    = (state_q == StClear);
    assign accept  = chipselect & clken & ~busy;
    assign rd_acc  = accept & ~write;
    assign wr_acc  = accept & write;
    assign rd_word = mem[address];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (init) begin
                    state_d = StClear;
                    cnt_d   = '0;
                end
            end
            StClear: begin
                // A fresh init restarts the sweep from word 0 without leaving CLEAR.
                if (init) begin
                    cnt_d = '0;
                end else if (&cnt_q) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Array has no reset; a reset mid-sweep simply stops the zero writes.
    always_ff @(posedge clk) begin
        if (busy) begin
            mem[cnt_q] <= '0;
        end else if (wr_acc) begin
            for (int b = 0; b < NB; b++) begin
                if (byteenable[b]) begin
                    mem[address][8*b +: 8] <= writedata[8*b +: 8];
                end
            end
        end
    end

    if (READ_LATENCY == 2) begin : g_lat2
        logic [DATA_W-1:0] s1_d_q;
        logic              s1_v_q;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                s1_v_q <= 1'b0;
                s1_d_q <= '0;
                rv_q   <= 1'b0;
                rd_q   <= '0;
            end else if (clken) begin
                s1_v_q <= rd_acc;
                if (rd_acc) begin
                    s1_d_q <= rd_word;
                end
                rv_q <= s1_v_q;
                if (s1_v_q) begin
                    rd_q <= s1_d_q;
                end
            end
        end
    end else begin : g_lat1
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                rv_q <= 1'b0;
                rd_q <= '0;
            end else if (clken) begin
                rv_q <= rd_acc;
                if (rd_acc) begin
                    rd_q <= rd_word;
                end
            end
        end
    end

    assign readdata      = rd_q;
    assign readdatavalid = rv_q;

endmodule

// File: tb/tb_pcm_mem_mm.sv
// Bench for pcm_mem_mm: latency-1 and latency-2 instances share stimulus and are checked every
// cycle against a queue-based memory model, plus literal expectations for the directed cases.
module tb_pcm_mem_mm;

    localparam int DEPTH = 2048;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        init = 1'b0;
    logic [10:0] address = '0;
    logic        chipselect = 1'b0;
    logic        clken = 1'b1;
    logic        write = 1'b0;
    logic [15:0] writedata = '0;
    logic [1:0]  byteenable = '0;
    logic [15:0] readdata, readdata2;
    logic        readdatavalid, readdatavalid2;
    logic        busy, busy2;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    pcm_mem_mm #(.ADDR_W(11), .DATA_W(16), .READ_LATENCY(1)) dut1 (
        .clk(clk), .reset(reset), .init(init), .address(address), .chipselect(chipselect),
        .clken(clken), .write(write), .writedata(writedata), .byteenable(byteenable),
        .readdata(readdata), .readdatavalid(readdatavalid), .busy(busy)
    );

    pcm_mem_mm #(.ADDR_W(11), .DATA_W(16), .READ_LATENCY(2)) dut2 (
        .clk(clk), .reset(reset), .init(init), .address(address), .chipselect(chipselect),
        .clken(clken), .write(write), .writedata(writedata), .byteenable(byteenable),
        .readdata(readdata2), .readdatavalid(readdatavalid2), .busy(busy2)
    );

    // ---------------- model ----------------
    typedef struct packed {
        logic        v;
        logic [15:0] d;
    } ent_t;

    logic [15:0] m_mem [DEPTH];
    ent_t        q1[$];
    ent_t        q2[$];
    ent_t        ne, o;
    logic [15:0] e_rd1, e_rd2;
    logic        e_v1, e_v2, e_busy, acc;
    int          clr_idx;

    // Each queue holds LATENCY-1 in-flight slots; one push and one pop per enabled cycle.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            e_rd1 = '0; e_rd2 = '0; e_v1 = 1'b0; e_v2 = 1'b0; e_busy = 1'b0; clr_idx = 0;
            q1.delete();
            q2.delete();
            q2.push_back('0);
        end else begin
            acc  = chipselect && clken && !e_busy;
            ne.v = acc && !write;
            ne.d = m_mem[address];
            if (clken) begin
                q1.push_back(ne);
                q2.push_back(ne);
                o = q1.pop_front();
                e_v1 = o.v;
                if (o.v) e_rd1 = o.d;
                o = q2.pop_front();
                e_v2 = o.v;
                if (o.v) e_rd2 = o.d;
            end
            if (acc && write)
                for (int b = 0; b < 2; b++)
                    if (byteenable[b]) m_mem[address][8*b +: 8] = writedata[8*b +: 8];
            if (e_busy) begin
                m_mem[clr_idx] = '0;
                if (init) clr_idx = 0;
                else if (clr_idx == DEPTH - 1) e_busy = 1'b0;
                else clr_idx++;
            end else if (init) begin
                e_busy  = 1'b1;
                clr_idx = 0;
            end
        end
    end

    task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cmp("rd1", {16'h0, readdata}, {16'h0, e_rd1});
            cmp("rdv1", {31'h0, readdatavalid}, {31'h0, e_v1});
            cmp("busy1", {31'h0, busy}, {31'h0, e_busy});
            cmp("rd2", {16'h0, readdata2}, {16'h0, e_rd2});
            cmp("rdv2", {31'h0, readdatavalid2}, {31'h0, e_v2});
            cmp("busy2", {31'h0, busy2}, {31'h0, e_busy});
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input logic cs, input logic wr, input logic [10:0] a, input logic [15:0] d,
                       input logic [1:0] be, input logic ce, input logic in);
        chipselect = cs; write = wr; address = a; writedata = d; byteenable = be;
        clken = ce; init = in;
        @(negedge clk);
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 11'h0, 16'h0, 2'b00, 1'b1, 1'b0);
    endtask

    task automatic wr_w(input logic [10:0] a, input logic [15:0] d, input logic [1:0] be);
        cyc(1'b1, 1'b1, a, d, be, 1'b1, 1'b0);
    endtask

    task automatic rd_chk(input string name, input logic [10:0] a, input logic [15:0] exp);
        int n;
        cyc(1'b1, 1'b0, a, 16'h0, 2'b00, 1'b1, 1'b0);
        n = 0;
        while (!readdatavalid && n < 8) begin
            idle();
            n++;
        end
        cmp({name, "_valid"}, {31'h0, readdatavalid}, 32'h1);
        cmp(name, {16'h0, readdata}, {16'h0, exp});
        idle();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog at %0t: got no finish, expected finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        #1 reset = 1'b0;
        @(negedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        cmp("rst_rd", {16'h0, readdata}, 32'h0);
        cmp("rst_rdv", {31'h0, readdatavalid}, 32'h0);
        cmp("rst_busy", {31'h0, busy}, 32'h0);
        #2 reset = 1'b1;
        @(negedge clk);

        wr_w(11'h010, 16'hA5C3, 2'b11);
        rd_chk("basic_rd", 11'h010, 16'hA5C3);

        wr_w(11'h3FF, 16'hBEEF, 2'b11);
        rd_chk("wr_then_rd", 11'h3FF, 16'hBEEF);

        wr_w(11'h020, 16'hFFFF, 2'b11);
        wr_w(11'h020, 16'h1234, 2'b01);
        rd_chk("be01", 11'h020, 16'hFF34);
        wr_w(11'h020, 16'h5600, 2'b10);
        rd_chk("be10", 11'h020, 16'h5634);
        wr_w(11'h020, 16'h9999, 2'b00);
        rd_chk("be00", 11'h020, 16'h5634);

        wr_w(11'h001, 16'h0101, 2'b11);
        wr_w(11'h002, 16'h0202, 2'b11);
        wr_w(11'h003, 16'h0303, 2'b11);
        cyc(1'b1, 1'b0, 11'h001, 16'h0, 2'b00, 1'b1, 1'b0);
        cmp("str_d1", {16'h0, readdata}, 32'h0101);
        cyc(1'b1, 1'b0, 11'h002, 16'h0, 2'b00, 1'b1, 1'b0);
        cmp("str_d2", {16'h0, readdata}, 32'h0202);
        cyc(1'b1, 1'b0, 11'h003, 16'h0, 2'b00, 1'b0, 1'b0);
        cmp("str_hold_v", {31'h0, readdatavalid}, 32'h1);
        cmp("str_hold_d", {16'h0, readdata}, 32'h0202);
        cyc(1'b1, 1'b0, 11'h003, 16'h0, 2'b00, 1'b1, 1'b0);
        cmp("str_d3", {16'h0, readdata}, 32'h0303);
        idle();
        cmp("str_end_v", {31'h0, readdatavalid}, 32'h0);
        cmp("str_end_d", {16'h0, readdata}, 32'h0303);
        idle();

        // Zero-fill, entered on the same edge as a read of pre-clear data.
        wr_w(11'h000, 16'h1234, 2'b11);
        wr_w(11'h7FF, 16'h7777, 2'b11);
        cyc(1'b1, 1'b0, 11'h010, 16'h0, 2'b00, 1'b1, 1'b1);
        cmp("init_rd", {16'h0, readdata}, 32'hA5C3);
        cmp("init_busy", {31'h0, busy}, 32'h1);
        n = 0;
        while (busy && n < 3000) begin
            n++;
            cyc(1'b1, n[0], (n[1] ? 11'h7FF : 11'h000), 16'hDEAD, 2'b11, 1'b1, 1'b0);
        end
        cmp("busy_len", n, 32'd2048);
        idle();
        rd_chk("clr_0", 11'h000, 16'h0000);
        rd_chk("clr_7ff", 11'h7FF, 16'h0000);

        // Reset aborting a sweep at counter 100, after one restart.
        wr_w(11'd98, 16'hC098, 2'b11);
        wr_w(11'd99, 16'hC099, 2'b11);
        wr_w(11'd100, 16'hC100, 2'b11);
        wr_w(11'd101, 16'hC101, 2'b11);
        cyc(1'b0, 1'b0, 11'h0, 16'h0, 2'b00, 1'b1, 1'b1);
        repeat (10) idle();
        cyc(1'b0, 1'b0, 11'h0, 16'h0, 2'b00, 1'b1, 1'b1);
        repeat (100) idle();
        #2 reset = 1'b0;
        #1 cmp("abort_busy", {31'h0, busy}, 32'h0);
        @(negedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
        rd_chk("abort_98", 11'd98, 16'h0000);
        rd_chk("abort_99", 11'd99, 16'h0000);
        rd_chk("abort_100", 11'd100, 16'hC100);
        rd_chk("abort_101", 11'd101, 16'hC101);

        // Reads in flight are dropped by reset.
        cyc(1'b1, 1'b0, 11'd101, 16'h0, 2'b00, 1'b1, 1'b0);
        idle();
        #2 reset = 1'b0;
        @(negedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
        cmp("flush_rdv", {31'h0, readdatavalid}, 32'h0);
        cmp("flush_rd", {16'h0, readdata}, 32'h0);
        repeat (4) idle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
